// File: rtl/led_blink_sequencer.sv
// FPro slot core that steps the blinker's four period inputs through a
// 4-entry pattern table, holding each entry for a programmable number of ticks.
module led_blink_sequencer #(
   parameter int TICK_DIV = 100000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs,
   input  logic        read,
   input  logic        write,
   input  logic [4:0]  addr,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic [15:0] num0,
   output logic [15:0] num1,
   output logic [15:0] num2,
   output logic [15:0] num3,
   output logic        busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] DWELL = 2'd2;

   localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);

   logic [1:0]    state;
   logic [1:0]    step;
   logic          done;
   logic          loop;
   logic [15:0]   dwell_cnt;
   logic [PW-1:0] presc;

   logic [15:0] tbl_n0    [4];
   logic [15:0] tbl_n1    [4];
   logic [15:0] tbl_n2    [4];
   logic [15:0] tbl_n3    [4];
   logic [15:0] tbl_dwell [4];

   logic       wr_en, ctrl_wr, tbl_wr, start, stop, tick;
   logic [1:0] tsel;
   logic       unused_read;

   // Reads have no side effects, so the read strobe is not needed.
   assign unused_read = read;

   assign wr_en   = cs & write;
   assign ctrl_wr = wr_en && (addr == 5'd0);
   assign tbl_wr  = wr_en && addr[4];
   assign stop    = ctrl_wr & wr_data[1];
   assign start   = ctrl_wr & wr_data[0] & ~wr_data[1];
   assign tick    = (presc == PRESC_LAST);
   assign tsel    = addr[3:2];
   assign busy    = (state == LOAD) || (state == DWELL);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            tbl_n0[i]    <= '0;
            tbl_n1[i]    <= '0;
            tbl_n2[i]    <= '0;
            tbl_n3[i]    <= '0;
            tbl_dwell[i] <= '0;
         end
      end else if (tbl_wr) begin
         case (addr[1:0])
            2'd0: begin
               tbl_n0[tsel] <= wr_data[15:0];
               tbl_n1[tsel] <= wr_data[31:16];
            end
            2'd1: begin
               tbl_n2[tsel] <= wr_data[15:0];
               tbl_n3[tsel] <= wr_data[31:16];
            end
            2'd2:    tbl_dwell[tsel] <= wr_data[15:0];
            default: ;
         endcase
      end
   end

   // Stop beats start; start restarts from step 0 even when already running.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         step      <= 2'd0;
         done      <= 1'b0;
         loop      <= 1'b0;
         dwell_cnt <= '0;
         presc     <= '0;
         num0      <= '0;
         num1      <= '0;
         num2      <= '0;
         num3      <= '0;
      end else begin
         if (ctrl_wr)
            loop <= wr_data[2];
         if (stop) begin
            state <= IDLE;
         end else if (start) begin
            state <= LOAD;
            step  <= 2'd0;
            done  <= 1'b0;
         end else begin
            case (state)
               IDLE: ;
               LOAD: begin
                  num0      <= tbl_n0[step];
                  num1      <= tbl_n1[step];
                  num2      <= tbl_n2[step];
                  num3      <= tbl_n3[step];
                  dwell_cnt <= (tbl_dwell[step] == 16'd0) ? 16'd1 : tbl_dwell[step];
                  presc     <= '0;
                  state     <= DWELL;
               end
               DWELL: begin
                  if (tick) begin
                     presc     <= '0;
                     dwell_cnt <= dwell_cnt - 16'd1;
                     if (dwell_cnt == 16'd1) begin
                        if (step != 2'd3) begin
                           step  <= step + 2'd1;
                           state <= LOAD;
                        end else if (loop) begin
                           step  <= 2'd0;
                           state <= LOAD;
                        end else begin
                           state <= IDLE;
                           done  <= 1'b1;
                        end
                     end
                  end else begin
                     presc <= presc + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   always_comb begin
      rd_data = '0;
      if (addr == 5'd0) begin
         rd_data = {29'b0, loop, 2'b0};
      end else if (addr == 5'd1) begin
         rd_data = {23'b0, done, 2'b0, step, 3'b0, busy};
      end else if (addr[4]) begin
         case (addr[1:0])
            2'd0:    rd_data = {tbl_n1[tsel], tbl_n0[tsel]};
            2'd1:    rd_data = {tbl_n3[tsel], tbl_n2[tsel]};
            2'd2:    rd_data = {16'b0, tbl_dwell[tsel]};
            default: rd_data = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Directed bench for led_blink_sequencer with TICK_DIV=4; expected cycle
// positions are hand-derived from the LOAD + dwell*TICK_DIV step timing.
module tb_led_blink_sequencer;

   logic        clk;
   logic        reset;
   logic        cs;
   logic        read;
   logic        write;
   logic [4:0]  addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic [15:0] num0, num1, num2, num3;
   logic        busy;

   int checks = 0;
   int errors = 0;

   logic [31:0] n01 [4] = '{32'h0020_0010, 32'h1200_1100, 32'h2200_2100, 32'h3200_3100};
   logic [31:0] n23 [4] = '{32'h0040_0030, 32'h1400_1300, 32'h2400_2300, 32'h3400_3300};
   logic [31:0] dw  [4] = '{32'd2, 32'd1, 32'd1, 32'd1};
   logic [31:0] r;

   led_blink_sequencer #(.TICK_DIV(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .cs      (cs),
      .read    (read),
      .write   (write),
      .addr    (addr),
      .wr_data (wr_data),
      .rd_data (rd_data),
      .num0    (num0),
      .num1    (num1),
      .num2    (num2),
      .num3    (num3),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Write lands on the next rising edge; returns 1 time unit after it.
   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
      @(posedge clk);
      #1;
      cs = 1'b0; write = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      addr = a;
      #1;
      d = rd_data;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_num01", {num1, num0}, 32'h0);
      chk("rst_num23", {num3, num2}, 32'h0);
      chk("rst_busy", busy, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      cyc(2);
      rd(5'd1, r); chk("rst_status", r, 32'h0);

      for (int s = 0; s < 4; s++) begin
         wr(5'(16 + 4*s), n01[s]);
         wr(5'(17 + 4*s), n23[s]);
         wr(5'(18 + 4*s), dw[s]);
      end
      wr(5'd19, 32'hFFFF_FFFF);
      wr(5'd2, 32'hFFFF_FFFF);
      rd(5'd17, r); chk("tbl_rd_w1", r, 32'h0040_0030);
      rd(5'd18, r); chk("tbl_rd_dwell", r, 32'h2);
      rd(5'd19, r); chk("tbl_rd_rsvd", r, 32'h0);
      rd(5'd2, r);  chk("rd_unmapped", r, 32'h0);

      // Single pass, start write at edge n
      wr(5'd0, 32'h1);
      chk("sp_busy_n", busy, 1'b1);
      chk("sp_num_n", {num1, num0}, 32'h0);
      cyc(1);
      chk("sp_s0_n1", {num1, num0}, n01[0]);
      chk("sp_s0_n1_hi", {num3, num2}, n23[0]);
      cyc(8);
      chk("sp_s0_n9", {num1, num0}, n01[0]);
      rd(5'd1, r); chk("sp_status_n9", r, 32'h11);
      cyc(1);
      chk("sp_s1_n10", {num1, num0}, n01[1]);
      cyc(5);
      chk("sp_s2_n15", {num1, num0}, n01[2]);
      cyc(5);
      chk("sp_s3_n20", {num1, num0}, n01[3]);
      chk("sp_s3_n20_hi", {num3, num2}, n23[3]);
      cyc(3);
      chk("sp_busy_n23", busy, 1'b1);
      cyc(1);
      chk("sp_busy_n24", busy, 1'b0);
      rd(5'd1, r); chk("sp_status_done", r, 32'h130);
      cyc(3);
      chk("sp_hold", {num3, num2, num1, num0}, {n23[3], n01[3]});

      // Loop run, start at edge m
      wr(5'd0, 32'h5);
      rd(5'd0, r); chk("lp_ctrl_rd", r, 32'h4);
      cyc(24);
      chk("lp_s3_m24", {num1, num0}, n01[3]);
      cyc(1);
      chk("lp_s0_again", {num1, num0}, n01[0]);
      rd(5'd1, r); chk("lp_status_m25", r, 32'h1);
      wr(5'd0, 32'h0);
      cyc(21);
      chk("lp_busy_m47", busy, 1'b1);
      rd(5'd1, r); chk("lp_status_m47", r, 32'h31);
      cyc(1);
      chk("lp_busy_m48", busy, 1'b0);
      rd(5'd1, r); chk("lp_status_end", r, 32'h130);
      rd(5'd0, r); chk("lp_ctrl_clr", r, 32'h0);

      // Dwell 0 on step2 plus a table rewrite during step0, start at edge p
      wr(5'd26, 32'h0);
      wr(5'd0, 32'h1);
      wr(5'd24, 32'hBEEF_0001);
      chk("d0_cur_unchanged", {num1, num0}, n01[0]);
      cyc(14);
      chk("d0_s2_p15", {num1, num0}, 32'hBEEF_0001);
      chk("d0_s2_p15_hi", {num3, num2}, n23[2]);
      cyc(4);
      chk("d0_s2_p19", {num1, num0}, 32'hBEEF_0001);
      rd(5'd1, r); chk("d0_status_p19", r, 32'h31);
      cyc(1);
      chk("d0_s3_p20", {num1, num0}, n01[3]);
      rd(5'd24, r); chk("d0_tbl_rd", r, 32'hBEEF_0001);
      cyc(4);
      chk("d0_busy_end", busy, 1'b0);

      // Stop during step1, start at edge q
      wr(5'd0, 32'h1);
      cyc(11);
      chk("st_s1", {num1, num0}, n01[1]);
      chk("st_busy_pre", busy, 1'b1);
      wr(5'd0, 32'h2);
      chk("st_busy", busy, 1'b0);
      chk("st_num", {num1, num0}, n01[1]);
      rd(5'd1, r); chk("st_status", r, 32'h10);
      cyc(6);
      chk("st_busy_hold", busy, 1'b0);
      chk("st_num_hold", {num3, num2, num1, num0}, {n23[1], n01[1]});

      // Start and stop together while idle
      wr(5'd0, 32'h3);
      chk("ss_busy", busy, 1'b0);
      rd(5'd1, r); chk("ss_status", r, 32'h10);
      cyc(3);
      chk("ss_busy_hold", busy, 1'b0);
      chk("ss_num_hold", {num1, num0}, n01[1]);

      // Asynchronous reset during DWELL
      wr(5'd0, 32'h1);
      cyc(4);
      chk("rr_busy_pre", busy, 1'b1);
      chk("rr_num_pre", {num1, num0}, n01[0]);
      #1 reset = 1'b1;
      #1;
      chk("rr_async_num01", {num1, num0}, 32'h0);
      chk("rr_async_num23", {num3, num2}, 32'h0);
      chk("rr_async_busy", busy, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      cyc(12);
      chk("rr_idle_busy", busy, 1'b0);
      chk("rr_idle_num", {num3, num2, num1, num0}, 64'h0);
      rd(5'd1, r);  chk("rr_status", r, 32'h0);
      rd(5'd16, r); chk("rr_tbl_clr", r, 32'h0);
      rd(5'd18, r); chk("rr_dwell_clr", r, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
